// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID boundary.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OP   = 5'b00000;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    DROP,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic        halt;
  } ifid_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, decode/EX-MEM control and IF/ID outputs.
interface fetch_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        stallCtrl;
  logic        takeBranch_EXMEM;
  logic [15:0] branchTarget_EXMEM;
  logic        jumpFlush;
  logic [15:0] jumpTarget;
  logic [15:0] instr_IFID;
  logic [15:0] PC_IFID;
  logic [15:0] PC2_IFID;
  logic        halt_IFID;
  logic        fetchBusy;

  modport master (
    output imem_addr, imem_rd, instr_IFID, PC_IFID, PC2_IFID, halt_IFID, fetchBusy,
    input  imem_data, imem_done, stallCtrl, takeBranch_EXMEM, branchTarget_EXMEM,
           jumpFlush, jumpTarget
  );

  modport slave (
    input  imem_addr, imem_rd, instr_IFID, PC_IFID, PC2_IFID, halt_IFID, fetchBusy,
    output imem_data, imem_done, stallCtrl, takeBranch_EXMEM, branchTarget_EXMEM,
           jumpFlush, jumpTarget
  );
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: load on enable, flush to a NOP bubble on redirect.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t ifid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_q <= '{instr: NOP_INSTR, pc: 16'h0000, pc2: 16'h0000, halt: 1'b0};
    end else if (flush_i) begin
      ifid_q <= '{instr: NOP_INSTR, pc: d_i.pc, pc2: d_i.pc2, halt: 1'b0};
    end else if (en_i) begin
      ifid_q <= d_i;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: sequences the PC, keeps one imem read in flight and
// feeds IF/ID, honouring decode stalls and EX/MEM redirects.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  hold_instr_q;
  logic [15:0]  hold_pc_q;
  logic         rd_q;

  logic         redirect;
  logic [15:0]  target;
  logic         load_valid;
  logic [15:0]  load_instr;
  logic [15:0]  load_pc;
  logic         ifid_en;
  ifid_t        ifid_d;
  ifid_t        ifid_q;

  always_comb begin
    redirect   = bus.takeBranch_EXMEM | bus.jumpFlush;
    target     = bus.takeBranch_EXMEM ? bus.branchTarget_EXMEM : bus.jumpTarget;
    load_valid = 1'b0;
    load_instr = bus.imem_data;
    load_pc    = pc_q;
    if (!bus.stallCtrl) begin
      if (state_q == WAIT && bus.imem_done) begin
        load_valid = 1'b1;
      end else if (state_q == HOLD) begin
        load_valid = 1'b1;
        load_instr = hold_instr_q;
        load_pc    = hold_pc_q;
      end
    end
    ifid_d.instr = load_valid ? load_instr : NOP_INSTR;
    ifid_d.pc    = load_pc;
    ifid_d.pc2   = load_pc + 16'd2;
    ifid_d.halt  = load_valid && is_halt(load_instr);
    // A halted stage keeps its HALT visible in IF/ID until a redirect squashes it.
    ifid_en      = !bus.stallCtrl && (state_q != HALTED);
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ifid_en),
    .flush_i (redirect),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  // rd_q mirrors "next cycle is a FETCH cycle"; FETCH without it is the post-reset arm cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= 16'h0000;
      hold_pc_q    <= 16'h0000;
      rd_q         <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      if (redirect) begin
        pc_q <= target;
        // An access still outstanding must be drained before the target is read.
        if ((state_q == WAIT || state_q == DROP) && !bus.imem_done) begin
          state_q <= DROP;
        end else begin
          state_q <= FETCH;
          rd_q    <= 1'b1;
        end
      end else if (load_valid) begin
        pc_q <= load_pc + 16'd2;
        if (is_halt(load_instr)) begin
          state_q <= HALTED;
        end else begin
          state_q <= FETCH;
          rd_q    <= 1'b1;
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (rd_q) state_q <= WAIT;
            else      rd_q    <= 1'b1;
          end
          WAIT: begin
            if (bus.imem_done) begin
              hold_instr_q <= bus.imem_data;
              hold_pc_q    <= pc_q;
              state_q      <= HOLD;
            end
          end
          DROP: begin
            if (bus.imem_done) begin
              state_q <= FETCH;
              rd_q    <= 1'b1;
            end
          end
          HOLD, HALTED: state_q <= state_q;
          default:      state_q <= FETCH;
        endcase
      end
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.imem_rd    = rd_q;
  assign bus.fetchBusy  = (state_q == WAIT) || (state_q == DROP);
  assign bus.instr_IFID = ifid_q.instr;
  assign bus.PC_IFID    = ifid_q.pc;
  assign bus.PC2_IFID   = ifid_q.pc2;
  assign bus.halt_IFID  = ifid_q.halt;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: variable-latency memory model plus cycle-exact checks.
module tb_fetch;

  logic clk = 1'b0;
  logic rst;
  fetch_if bus ();

  fetch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents at the addresses the vectors touch.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hC001;
      16'h0002: return 16'hC002;
      16'h0004: return 16'hC003;
      16'h0006: return 16'hC006;
      16'h0100: return 16'h0000;
      16'h0040: return 16'hC040;
      16'h0042: return 16'hC042;
      16'hFFFE: return 16'hC0FE;
      default:  return 16'h1234;
    endcase
  endfunction

  int          mem_lat  = 1;
  int          rd_cnt   = 0;
  logic        pend     = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;

  // Instruction memory: done arrives mem_lat cycles after the cycle imem_rd was high.
  always @(posedge clk) begin
    bus.imem_done <= 1'b0;
    if (bus.imem_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (mem_lat <= 1) begin
        bus.imem_done <= 1'b1;
        bus.imem_data <= mem_word(bus.imem_addr);
        pend          <= 1'b0;
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= mem_lat - 1;
        pend_addr <= bus.imem_addr;
      end
    end else if (pend) begin
      if (pend_cnt == 1) begin
        bus.imem_done <= 1'b1;
        bus.imem_data <= mem_word(pend_addr);
        pend          <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  int snap;

  initial begin
    rst                    = 1'b0;
    bus.imem_done          = 1'b0;
    bus.imem_data          = 16'h0000;
    bus.stallCtrl          = 1'b0;
    bus.takeBranch_EXMEM   = 1'b0;
    bus.branchTarget_EXMEM = 16'h0000;
    bus.jumpFlush          = 1'b0;
    bus.jumpTarget         = 16'h0000;

    repeat (3) @(negedge clk);
    check_eq("rst_instr", bus.instr_IFID, 16'h0800);
    check_eq("rst_pc", bus.PC_IFID, 16'h0000);
    check_eq("rst_pc2", bus.PC2_IFID, 16'h0000);
    check_eq("rst_halt", {15'd0, bus.halt_IFID}, 16'd0);
    check_eq("rst_rd", {15'd0, bus.imem_rd}, 16'd0);
    check_eq("rst_busy", {15'd0, bus.fetchBusy}, 16'd0);
    rst = 1'b1;

    // Straight-line fetch, latency 1
    @(negedge clk);
    check_eq("t1_rd0", {15'd0, bus.imem_rd}, 16'd1);
    check_eq("t1_addr0", bus.imem_addr, 16'h0000);
    @(negedge clk);
    check_eq("t1_rd_low", {15'd0, bus.imem_rd}, 16'd0);
    check_eq("t1_busy", {15'd0, bus.fetchBusy}, 16'd1);
    check_eq("t1_nop0", bus.instr_IFID, 16'h0800);
    @(negedge clk);
    check_eq("t1_instr1", bus.instr_IFID, 16'hC001);
    check_eq("t1_pc1", bus.PC_IFID, 16'h0000);
    check_eq("t1_pc2_1", bus.PC2_IFID, 16'h0002);
    check_eq("t1_rd1", {15'd0, bus.imem_rd}, 16'd1);
    check_eq("t1_addr1", bus.imem_addr, 16'h0002);
    @(negedge clk);
    check_eq("t1_nop1", bus.instr_IFID, 16'h0800);
    check_eq("t1_nop1_pc", bus.PC_IFID, 16'h0002);
    check_eq("t1_nop1_pc2", bus.PC2_IFID, 16'h0004);
    @(negedge clk);
    check_eq("t1_instr2", bus.instr_IFID, 16'hC002);
    check_eq("t1_pc2", bus.PC_IFID, 16'h0002);
    check_eq("t1_pc2_2", bus.PC2_IFID, 16'h0004);
    check_eq("t1_addr2", bus.imem_addr, 16'h0004);

    // Stall across completion
    bus.stallCtrl = 1'b1;
    @(negedge clk);
    check_eq("t2_hold_a", bus.instr_IFID, 16'hC002);
    snap = rd_cnt;
    @(negedge clk);
    check_eq("t2_hold_b", bus.instr_IFID, 16'hC002);
    check_eq("t2_notbusy", {15'd0, bus.fetchBusy}, 16'd0);
    @(negedge clk);
    check_eq("t2_hold_c", bus.instr_IFID, 16'hC002);
    check_eq("t2_no_rd", {15'd0, bus.imem_rd}, 16'd0);
    bus.stallCtrl = 1'b0;
    @(negedge clk);
    check_eq("t2_instr", bus.instr_IFID, 16'hC003);
    check_eq("t2_pc", bus.PC_IFID, 16'h0004);
    check_eq("t2_pc2", bus.PC2_IFID, 16'h0006);
    check_eq("t2_rdcnt", rd_cnt[15:0], snap[15:0]);
    check_eq("t2_addr", bus.imem_addr, 16'h0006);

    // Redirect while a latency-3 access is in flight
    mem_lat = 3;
    @(negedge clk);
    check_eq("t3_busy", {15'd0, bus.fetchBusy}, 16'd1);
    bus.takeBranch_EXMEM   = 1'b1;
    bus.branchTarget_EXMEM = 16'h0100;
    bus.jumpFlush          = 1'b1;
    bus.jumpTarget         = 16'h0200;
    @(negedge clk);
    bus.takeBranch_EXMEM = 1'b0;
    bus.jumpFlush        = 1'b0;
    check_eq("t3_nop", bus.instr_IFID, 16'h0800);
    check_eq("t3_halt", {15'd0, bus.halt_IFID}, 16'd0);
    check_eq("t3_addr", bus.imem_addr, 16'h0100);
    check_eq("t3_drop_busy", {15'd0, bus.fetchBusy}, 16'd1);
    check_eq("t3_drop_rd", {15'd0, bus.imem_rd}, 16'd0);
    mem_lat = 1;
    @(negedge clk);
    check_eq("t3_drop_wait_rd", {15'd0, bus.imem_rd}, 16'd0);
    @(negedge clk);
    check_eq("t3_rd_tgt", {15'd0, bus.imem_rd}, 16'd1);
    check_eq("t3_addr_tgt", bus.imem_addr, 16'h0100);
    check_eq("t3_discard", bus.instr_IFID, 16'h0800);

    // HALT at 0x0100, then jump resumes at 0x0040
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_halt", {15'd0, bus.halt_IFID}, 16'd1);
    check_eq("t4_instr", bus.instr_IFID, 16'h0000);
    check_eq("t4_pc", bus.PC_IFID, 16'h0100);
    snap = rd_cnt;
    repeat (4) @(negedge clk);
    check_eq("t4_no_rd_cnt", rd_cnt[15:0], snap[15:0]);
    check_eq("t4_no_rd", {15'd0, bus.imem_rd}, 16'd0);
    bus.jumpFlush  = 1'b1;
    bus.jumpTarget = 16'h0040;
    @(negedge clk);
    bus.jumpFlush = 1'b0;
    check_eq("t4_unhalt", {15'd0, bus.halt_IFID}, 16'd0);
    check_eq("t4_nop", bus.instr_IFID, 16'h0800);
    check_eq("t4_rd", {15'd0, bus.imem_rd}, 16'd1);
    check_eq("t4_addr", bus.imem_addr, 16'h0040);
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_resume", bus.instr_IFID, 16'hC040);
    check_eq("t4_resume_pc2", bus.PC2_IFID, 16'h0042);

    // Jump to 0xFFFE on the completion cycle, then wrap
    @(negedge clk);
    bus.jumpFlush  = 1'b1;
    bus.jumpTarget = 16'hFFFE;
    @(negedge clk);
    bus.jumpFlush = 1'b0;
    check_eq("t5_rd", {15'd0, bus.imem_rd}, 16'd1);
    check_eq("t5_addr", bus.imem_addr, 16'hFFFE);
    check_eq("t5_nop", bus.instr_IFID, 16'h0800);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_instr", bus.instr_IFID, 16'hC0FE);
    check_eq("t5_pc", bus.PC_IFID, 16'hFFFE);
    check_eq("t5_pc2_wrap", bus.PC2_IFID, 16'h0000);
    check_eq("t5_addr_wrap", bus.imem_addr, 16'h0000);
    check_eq("t5_rd_wrap", {15'd0, bus.imem_rd}, 16'd1);

    // Asynchronous reset in the middle of WAIT
    mem_lat = 4;
    @(negedge clk);
    check_eq("t6_busy", {15'd0, bus.fetchBusy}, 16'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rd", {15'd0, bus.imem_rd}, 16'd0);
    check_eq("t6_busy0", {15'd0, bus.fetchBusy}, 16'd0);
    check_eq("t6_instr", bus.instr_IFID, 16'h0800);
    check_eq("t6_pc", bus.PC_IFID, 16'h0000);
    check_eq("t6_pc2", bus.PC2_IFID, 16'h0000);
    check_eq("t6_halt", {15'd0, bus.halt_IFID}, 16'd0);
    check_eq("t6_addr", bus.imem_addr, 16'h0000);
    mem_lat = 1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_restart_rd", {15'd0, bus.imem_rd}, 16'd1);
    check_eq("t6_restart_addr", bus.imem_addr, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
